// File: rtl/shared_pkg.sv
// shared_pkg: FIFO-wide constants and word type shared by the FIFO and its drain logic.
package shared_pkg;
  localparam int FIFO_WIDTH      = 16;
  localparam int FIFO_DEPTH      = 16;
  localparam int DRAIN_BUF_DEPTH = 3;
  localparam int XFER_CNT_WIDTH  = 16;
  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/drain_elastic_buf.sv
// drain_elastic_buf: DEPTH-entry circular buffer with push/pop and occupancy.
// Ports: clk, rst (async high), push/din write at wr_ptr, pop advances rd_ptr,
// dout is the head word (0 when empty), occ is the number of stored words.
module drain_elastic_buf
  import shared_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = DRAIN_BUF_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [OW-1:0]    occ
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      occ <= occ + OW'(push) - OW'(pop);
    end
  // storage is deliberately left unreset; the empty case is masked on dout
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  assign dout = occ == '0 ? '0 : mem[rd_ptr];
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pops the synchronous FIFO, absorbs its 1-cycle read latency, streams words out.
// Ports: clk, rst (async high), enable gates new reads, fifo_empty/fifo_dout/fifo_rd_en
// face the FIFO read port, m_valid/m_data/m_ready form the output stream,
// xfer_count counts handshakes (wrapping), busy flags buffered or in-flight words.
module fifo_drain
  import shared_pkg::*;
#(
  parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
  parameter int BUF_DEPTH  = DRAIN_BUF_DEPTH,
  parameter int CNT_WIDTH  = XFER_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  busy
);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  logic [OW-1:0] occ;
  logic inflight, req, pop;
  // a read is a credit: issue only if the word can land even with no pop
  assign req = enable && !fifo_empty && ({1'b0, occ} + (OW + 1)'(inflight)) < (OW + 1)'(BUF_DEPTH);
  // reset masks the request combinationally so it drops the moment rst rises
  assign fifo_rd_en = req && !rst;
  assign m_valid = occ != '0;
  assign pop = m_valid && m_ready;
  assign busy = m_valid || inflight;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inflight   <= 1'b0;
      xfer_count <= '0;
    end else begin
      inflight   <= req;
      xfer_count <= xfer_count + CNT_WIDTH'(pop);
    end
  drain_elastic_buf #(.WIDTH(FIFO_WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
    .clk (clk),
    .rst (rst),
    .push(inflight),
    .din (fifo_dout),
    .pop (pop),
    .dout(m_data),
    .occ (occ)
  );
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: randomized bench for fifo_drain against a FIFO model and word-level scoreboard.
module tb_fifo_drain;
  logic clk = 0, rst = 1, enable = 1, fifo_empty = 1, m_ready = 0;
  logic [15:0] fifo_dout = '0;
  logic fifo_rd_en, m_valid, busy, fifo_rd_en4, m_valid4, busy4;
  logic [15:0] m_data, m_data4, xfer_count;
  logic [3:0] xfer4;
  int checks = 0, errors = 0;
  logic [15:0] q[$], exp_q[$];
  int avail = 0, pend = 0, total = 0, cyc = 0, t_rd = -1, t_val = -1, n_rd = 0, base = 0;
  always #5 clk = ~clk;
  fifo_drain u_dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .xfer_count(xfer_count), .busy(busy)
  );
  fifo_drain #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en4), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready),
    .xfer_count(xfer4), .busy(busy4)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  task automatic push(input logic [15:0] w);
    q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    q.delete();
    exp_q.delete();
    fifo_empty = 1;
    avail = 0;
    pend = 0;
    total = 0;
  endtask
  // one clock: check outputs mid-cycle, then advance FIFO and model at the edge
  task automatic step();
    logic e_rd, e_valid, e_hs, rd;
    logic [15:0] head;
    #1;
    e_valid = avail > 0;
    e_hs = e_valid && m_ready;
    e_rd = !rst && enable && q.size() != 0 && (avail + pend) < 3;
    head = (e_valid && exp_q.size() != 0) ? exp_q[0] : 16'h0;
    rd = fifo_rd_en;
    check("rd_en", rd, e_rd);
    check("underflow", rd && fifo_empty, 0);
    check("m_valid", m_valid, e_valid);
    check("m_data", m_data, head);
    check("busy", busy, e_valid || pend != 0);
    check("xfer_count", xfer_count, 32'(total % 65536));
    check("occ_max", u_dut.occ <= 3, 1);
    check("rd_en4", fifo_rd_en4, e_rd);
    check("m_data4", m_data4, head);
    check("busy4", busy4, e_valid || pend != 0);
    check("xfer4", xfer4, 32'(total % 16));
    if (rd) begin
      n_rd++;
      if (t_rd < 0) t_rd = cyc;
    end
    if (m_valid && t_val < 0) t_val = cyc;
    if (e_hs) begin
      void'(exp_q.pop_front());
      total++;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      avail = 0;
      pend = 0;
    end else begin
      avail = avail + pend - (e_hs ? 1 : 0);
      pend = e_rd ? 1 : 0;
    end
    if (rd && q.size() != 0) fifo_dout = q.pop_front();
    fifo_empty = q.size() == 0;
    cyc++;
    @(negedge clk);
  endtask
  task automatic drain();
    m_ready = 1;
    enable = 1;
    for (int i = 0; i < 1000 && (exp_q.size() != 0 || pend != 0 || avail != 0); i++) step();
    check("drain_done", exp_q.size() + avail + pend, 0);
  endtask
  initial begin
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push(16'(i));
    step();
    step();
    rst = 0;
    t_rd = -1;
    t_val = -1;
    drain();
    check("latency", t_val - t_rd, 2);
    check("burst_count", xfer_count, 8);
    check("busy_idle", busy, 0);
    m_ready = 0;
    n_rd = 0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    for (int i = 0; i < 10; i++) step();
    check("reads_stall", n_rd, 3);
    check("held_data", m_data, 16'h0001);
    check("rd_idle", fifo_rd_en, 0);
    drain();
    check("stall_count", xfer_count, 16);
    n_rd = 0;
    for (int i = 0; i < 10; i++) step();
    check("empty_reads", n_rd, 0);
    check("empty_valid", m_valid, 0);
    base = total;
    push(16'hBEEF);
    drain();
    check("beef_count", xfer_count, 32'(base + 1));
    for (int i = 0; i < 400; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      enable = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 2) == 0)
        case ($urandom_range(0, 2))
          0: push(16'hFFFF);
          1: push(16'h0000);
          default: push(16'($urandom));
        endcase
      step();
    end
    drain();
    m_ready = 0;
    for (int i = 1; i <= 8; i++) push(16'(16'h0010 + i));
    for (int i = 0; i < 20 && !(avail == 2 && pend == 1); i++) step();
    check("pre_rst_state", avail == 2 && pend == 1, 1);
    do_reset();
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_xfer", xfer_count, 0);
    check("rst_m_data", m_data, 0);
    step();
    rst = 0;
    push(16'h1234);
    drain();
    check("post_rst_count", xfer_count, 1);
    for (int i = 0; i < 19; i++) push(16'($urandom));
    drain();
    check("count20", xfer_count, 20);
    check("count4_wrap", xfer4, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
